// File: rtl/vpu_pkg.sv
// Shared constants for the VPU sequencer slice: word/address/length widths,
// opcode encodings and the sequencer FSM state type.
package vpu_pkg;

    localparam int NUM_SIZE        = 16;
    localparam int VEC_BUFFER_LEN  = 8;
    localparam int WORDS_IN_MEMORY = 32;
    localparam int ADDR_W          = 5;
    localparam int LEN_W           = 3;
    localparam int OPC_W           = 6;

    localparam logic [OPC_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OPC_W-1:0] OP_VADD  = 6'd2;
    localparam logic [OPC_W-1:0] OP_MOVE  = 6'd3;
    localparam logic [OPC_W-1:0] OP_RELU  = 6'd4;
    localparam logic [OPC_W-1:0] OP_VSMUL = 6'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_WRITE
    } seq_state_t;

    // True for opcodes the VPU actually executes (NOP is handled locally)
    function automatic logic op_is_vector(input logic [OPC_W-1:0] op);
        case (op)
            OP_VADD, OP_MOVE, OP_RELU, OP_VSMUL: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vpu_writeback.sv
// Capture/write-back datapath of the VPU sequencer: snapshots the VPU result
// buffer on a start pulse, then streams it into the scratchpad one word per
// cycle at a wrapping 5-bit address. A length of 0 means a full buffer.
module vpu_writeback
    import vpu_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [NUM_SIZE*VEC_BUFFER_LEN-1:0] flat_buf,
    input  logic [ADDR_W-1:0]                  dest,
    input  logic [LEN_W-1:0]                   length,
    output logic                               mem_we,
    output logic [ADDR_W-1:0]                  mem_waddr,
    output logic [NUM_SIZE-1:0]                mem_wdata,
    output logic                               last,
    output logic                               last_nxt
);

    logic [NUM_SIZE-1:0] snap [VEC_BUFFER_LEN];
    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    n_m1;
    logic [LEN_W-1:0]    cnt_nxt;

    // Word count minus one wraps naturally: length 0 gives 7, i.e. 8 words
    assign cnt_nxt  = cnt + LEN_W'(1);
    assign last     = mem_we && (cnt == n_m1);
    assign last_nxt = start ? (length == LEN_W'(1))
                            : (mem_we && (cnt_nxt == n_m1));

    // Snapshot on start, then advance one word and one address per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < VEC_BUFFER_LEN; i++) begin
                snap[i] <= '0;
            end
            cnt       <= '0;
            n_m1      <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            for (int i = 0; i < VEC_BUFFER_LEN; i++) begin
                snap[i] <= flat_buf[i*NUM_SIZE +: NUM_SIZE];
            end
            cnt       <= '0;
            n_m1      <= length - LEN_W'(1);
            mem_we    <= 1'b1;
            mem_waddr <= dest;
            mem_wdata <= flat_buf[NUM_SIZE-1:0];
        end else if (mem_we) begin
            if (last) begin
                mem_we <= 1'b0;
            end else begin
                cnt       <= cnt_nxt;
                mem_waddr <= mem_waddr + ADDR_W'(1);
                mem_wdata <= snap[cnt_nxt];
            end
        end
    end

endmodule

// File: rtl/vpu_sequencer.sv
// Single-issue VPU instruction sequencer: accepts one instruction over
// valid/ready, issues it to the VPU for one cycle, captures the result buffer
// and writes it back to the scratchpad before accepting the next one.
// Optional feature macro VPU_SEQ_PERF_CNT_EN adds saturating counters
// perf_instr_cnt (retired, non-error instructions) and perf_word_cnt
// (scratchpad words written).
module vpu_sequencer
    import vpu_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               instr_valid,
    output logic                               instr_ready,
    input  logic [OPC_W-1:0]                   instr_opcode,
    input  logic [ADDR_W-1:0]                  instr_op1,
    input  logic [ADDR_W-1:0]                  instr_op2,
    input  logic [ADDR_W-1:0]                  instr_op3,
    input  logic [LEN_W-1:0]                   instr_op4,
    output logic [OPC_W-1:0]                   vpu_opcode,
    output logic [ADDR_W-1:0]                  vpu_operand1,
    output logic [ADDR_W-1:0]                  vpu_operand2,
    output logic [ADDR_W-1:0]                  vpu_operand3,
    output logic [LEN_W-1:0]                   vpu_operand4,
    input  logic [NUM_SIZE*VEC_BUFFER_LEN-1:0] vpu_flat_vec_buffer,
    input  logic                               vpu_copy_flag,
    input  logic [ADDR_W-1:0]                  vpu_dest,
    input  logic [LEN_W-1:0]                   vpu_length,
    output logic                               mem_we,
    output logic [ADDR_W-1:0]                  mem_waddr,
    output logic [NUM_SIZE-1:0]                mem_wdata,
    output logic                               busy,
    output logic                               done,
    output logic                               err
`ifdef VPU_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]                        perf_instr_cnt,
    output logic [15:0]                        perf_word_cnt
`endif
);

    seq_state_t state;
    logic       wb_start;
    logic       wb_last;
    logic       wb_last_nxt;

    // The VPU result is only trusted when it signals a valid copy
    assign wb_start = (state == ST_CAPTURE) && vpu_copy_flag;

    vpu_writeback u_writeback (
        .clk       (clk),
        .rst       (rst),
        .start     (wb_start),
        .flat_buf  (vpu_flat_vec_buffer),
        .dest      (vpu_dest),
        .length    (vpu_length),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .last      (wb_last),
        .last_nxt  (wb_last_nxt)
    );

    // Control FSM; every output is registered and ready mirrors IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            instr_ready  <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            vpu_opcode   <= OP_NOP;
            vpu_operand1 <= '0;
            vpu_operand2 <= '0;
            vpu_operand3 <= '0;
            vpu_operand4 <= '0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            vpu_opcode <= OP_NOP;
            case (state)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        if (instr_opcode == OP_NOP) begin
                            done <= 1'b1;
                        end else if (!op_is_vector(instr_opcode)) begin
                            // Illegal opcodes never reach the VPU
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            state        <= ST_ISSUE;
                            instr_ready  <= 1'b0;
                            busy         <= 1'b1;
                            vpu_opcode   <= instr_opcode;
                            vpu_operand1 <= instr_op1;
                            vpu_operand2 <= instr_op2;
                            vpu_operand3 <= instr_op3;
                            vpu_operand4 <= instr_op4;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (vpu_copy_flag) begin
                        state <= ST_WRITE;
                        done  <= wb_last_nxt;
                    end else begin
                        state       <= ST_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        err         <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // done is raised one edge early so it lines up with the last word
                    done <= wb_last_nxt;
                    if (wb_last) begin
                        state       <= ST_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef VPU_SEQ_PERF_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating event counters fed from the registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_instr_cnt <= '0;
            perf_word_cnt  <= '0;
        end else begin
            if (done && !err) begin
                perf_instr_cnt <= sat_inc(perf_instr_cnt);
            end
            if (mem_we) begin
                perf_word_cnt <= sat_inc(perf_word_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vpu_sequencer.sv
// Testbench for vpu_sequencer: mock VPU + scratchpad around the DUT, an
// instruction-level reference model, a per-cycle compare process and
// directed vectors with hand-computed write-back values.
`timescale 1ns/1ps
module tb_vpu_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [5:0]   instr_opcode = '0;
    logic [4:0]   instr_op1 = '0, instr_op2 = '0, instr_op3 = '0;
    logic [2:0]   instr_op4 = '0;
    logic [5:0]   vpu_opcode;
    logic [4:0]   vpu_operand1, vpu_operand2, vpu_operand3;
    logic [2:0]   vpu_operand4;
    logic [127:0] v_buf;
    logic         v_flag;
    logic [4:0]   v_dest;
    logic [2:0]   v_len;
    logic         mem_we;
    logic [4:0]   mem_waddr;
    logic [15:0]  mem_wdata;
    logic         busy, done, err;
`ifdef VPU_SEQ_PERF_CNT_EN
    logic [15:0]  perf_instr_cnt, perf_word_cnt;
    int           p_instr = 0, p_word = 0;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vpu_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .instr_opcode        (instr_opcode),
        .instr_op1           (instr_op1),
        .instr_op2           (instr_op2),
        .instr_op3           (instr_op3),
        .instr_op4           (instr_op4),
        .vpu_opcode          (vpu_opcode),
        .vpu_operand1        (vpu_operand1),
        .vpu_operand2        (vpu_operand2),
        .vpu_operand3        (vpu_operand3),
        .vpu_operand4        (vpu_operand4),
        .vpu_flat_vec_buffer (v_buf),
        .vpu_copy_flag       (v_flag),
        .vpu_dest            (v_dest),
        .vpu_length          (v_len),
        .mem_we              (mem_we),
        .mem_waddr           (mem_waddr),
        .mem_wdata           (mem_wdata),
        .busy                (busy),
        .done                (done),
        .err                 (err)
`ifdef VPU_SEQ_PERF_CNT_EN
        ,
        .perf_instr_cnt      (perf_instr_cnt),
        .perf_word_cnt       (perf_word_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- VPU instruction semantics (shared by mock and model)
    function automatic logic [15:0] init_val(input int i);
        if (i < 8) return 16'(i + 3);
        return 16'(-(i * 3));
    endfunction

    function automatic void decode(input logic [5:0] op, input logic [4:0] a, b, c,
                                   input logic [2:0] d, output int sa, output int sb,
                                   output int dst, output int len);
        sa = int'(a); sb = int'(b); dst = 0; len = 0;
        case (op)
            6'd3, 6'd4: begin dst = int'(b); len = int'(c) % 8; end
            6'd2, 6'd5: begin dst = int'(c); len = int'(d); end
            default: ;
        endcase
    endfunction

    function automatic logic [15:0] vword(input logic [5:0] op, input logic [15:0] m [32],
                                          input int sa, input int sb, input int k);
        logic signed [15:0] x, y;
        logic signed [31:0] p;
        x = m[(sa + k) % 32];
        case (op)
            6'd3: return x;
            6'd2: begin y = m[(sb + k) % 32]; return 16'(x + y); end
            6'd4: return (x < 0) ? 16'd0 : x;
            6'd5: begin y = m[sb % 32]; p = x * y; return p[15:0]; end
            default: return 16'd0;
        endcase
    endfunction

    // ---------------- mock VPU and scratchpad
    logic [15:0] smem [32];
    logic        loaded = 1'b0;
    logic        drop_flag = 1'b0;
    int          v_sa, v_sb, v_dst, v_ln;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32; i++) smem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (mem_we) begin
            smem[mem_waddr] <= mem_wdata;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_flag <= 1'b0; v_dest <= '0; v_len <= '0; v_buf <= '0;
        end else if (vpu_opcode != 6'd0) begin
            decode(vpu_opcode, vpu_operand1, vpu_operand2, vpu_operand3, vpu_operand4,
                   v_sa, v_sb, v_dst, v_ln);
            for (int k = 0; k < 8; k++)
                v_buf[k*16 +: 16] <= vword(vpu_opcode, smem, v_sa, v_sb, k);
            v_flag <= !drop_flag;
            v_dest <= 5'(v_dst);
            v_len  <= 3'(v_ln);
        end else begin
            v_flag <= 1'b0;
        end
    end

    // ---------------- reference model (instruction level)
    logic [15:0] mmem [32];
    int          m_act = 0;   // 0 none, 1 vector, 2 nop, 3 illegal, 4 no copy flag
    int          m_E = 0, m_N = 0, m_dest = 0;
    logic [15:0] m_buf [8];
    logic [5:0]  m_opc = '0;
    logic [4:0]  m_o1 = '0, m_o2 = '0, m_o3 = '0;
    logic [2:0]  m_o4 = '0;

    task automatic model_accept(input logic [5:0] op, input logic [4:0] a, b, c,
                                input logic [2:0] d, input int e_edge);
        int sa, sb, dst, len;
        m_E = e_edge;
        if (op == 6'd0) begin
            m_act = 2;
        end else if (!(op inside {6'd2, 6'd3, 6'd4, 6'd5})) begin
            m_act = 3;
        end else begin
            m_opc = op; m_o1 = a; m_o2 = b; m_o3 = c; m_o4 = d;
            decode(op, a, b, c, d, sa, sb, dst, len);
            m_N = (len == 0) ? 8 : len;
            m_dest = dst;
            if (drop_flag) begin
                m_act = 4;
            end else begin
                m_act = 1;
                for (int k = 0; k < 8; k++) m_buf[k] = vword(op, mmem, sa, sb, k);
                for (int k = 0; k < m_N; k++) mmem[(dst + k) % 32] = m_buf[k];
            end
        end
    endtask

    // ---------------- per-cycle compare process
    int          k;
    logic        e_ready, e_busy, e_done, e_err, e_we;
    logic [5:0]  e_op;
    logic [4:0]  e_addr;
    logic [15:0] e_data;
    int          wn = 0, dn = 0, en = 0, last_done = -1;
    logic [4:0]  wlog_a [256];
    logic [15:0] wlog_d [256];
    int          wlog_c [256];

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_instr_ready", instr_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_waddr", mem_waddr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_vpu_opcode", vpu_opcode, 0);
            chk("rst_operands", {vpu_operand1, vpu_operand2, vpu_operand3, vpu_operand4}, 0);
`ifdef VPU_SEQ_PERF_CNT_EN
            p_instr = 0; p_word = 0;
            chk("rst_perf_instr", perf_instr_cnt, 0);
            chk("rst_perf_word", perf_word_cnt, 0);
`endif
        end else begin
            k = cyc - m_E + 1;
            e_ready = 1; e_busy = 0; e_done = 0; e_err = 0; e_we = 0;
            e_op = '0; e_addr = '0; e_data = '0;
            case (m_act)
                1: begin
                    if (k >= 1 && k <= m_N + 2) begin e_ready = 0; e_busy = 1; end
                    if (k == 1) e_op = m_opc;
                    if (k >= 3 && k <= m_N + 2) begin
                        e_we = 1;
                        e_addr = 5'((m_dest + k - 3) % 32);
                        e_data = m_buf[3'(k - 3)];
                    end
                    if (k == m_N + 2) e_done = 1;
                end
                2: if (k == 1) e_done = 1;
                3: if (k == 1) begin e_done = 1; e_err = 1; end
                4: begin
                    if (k == 1 || k == 2) begin e_ready = 0; e_busy = 1; end
                    if (k == 1) e_op = m_opc;
                    if (k == 3) begin e_done = 1; e_err = 1; end
                end
                default: ;
            endcase
            chk("instr_ready", instr_ready, e_ready);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("mem_we", mem_we, e_we);
            chk("vpu_opcode", vpu_opcode, e_op);
            chk("operands", {vpu_operand1, vpu_operand2, vpu_operand3, vpu_operand4},
                {m_o1, m_o2, m_o3, m_o4});
            if (e_we) begin
                chk("mem_waddr", mem_waddr, e_addr);
                chk("mem_wdata", mem_wdata, e_data);
            end
`ifdef VPU_SEQ_PERF_CNT_EN
            chk("perf_instr", perf_instr_cnt, p_instr);
            chk("perf_word", perf_word_cnt, p_word);
            if (e_done && !e_err) p_instr++;
            if (e_we) p_word++;
`endif
            if (mem_we && wn < 256) begin
                wlog_a[wn] = mem_waddr; wlog_d[wn] = mem_wdata; wlog_c[wn] = cyc; wn++;
            end
            if (done) begin dn++; last_done = cyc; end
            if (err) en++;
        end
    end

    // ---------------- driver
    task automatic send(input logic [5:0] op, input logic [4:0] a, b, c,
                        input logic [2:0] d, input bit keep, output int e_edge);
        int t, c0;
        bit got;
        got = 0; t = 0; e_edge = -100;
        instr_opcode = op; instr_op1 = a; instr_op2 = b; instr_op3 = c; instr_op4 = d;
        instr_valid = 1'b1;
        while (!got && t < 64) begin
            @(negedge clk);
            if (instr_ready) begin
                c0 = cyc;
                @(posedge clk);
                e_edge = c0 + 1;
                model_accept(op, a, b, c, d, e_edge);
                got = 1;
            end
            t++;
        end
        #1;
        if (!keep) instr_valid = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL send_timeout: opcode %0d never accepted within 64 cycles", op);
        end
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int E, E2, w0, d0, e0;
    logic [5:0] bad_ops [4];

    initial begin
        for (int i = 0; i < 32; i++) mmem[i] = init_val(i);
        bad_ops[0] = 6'd1; bad_ops[1] = 6'd7; bad_ops[2] = 6'd6; bad_ops[3] = 6'd63;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // MOVE src 4 -> dest 10, 3 words: 7,8,9
        w0 = wn; d0 = dn;
        send(6'd3, 5'd4, 5'd10, 5'd3, 3'd0, 0, E);
        settle();
        chk("move_nwrites", wn - w0, 3);
        chk("move_w0", {wlog_a[w0], wlog_d[w0]}, {5'd10, 16'd7});
        chk("move_w1", {wlog_a[w0+1], wlog_d[w0+1]}, {5'd11, 16'd8});
        chk("move_w2", {wlog_a[w0+2], wlog_d[w0+2]}, {5'd12, 16'd9});
        chk("move_first_write_cycle", wlog_c[w0] - E, 2);
        chk("move_done_cycle", last_done - E, 4);
        chk("move_done_count", dn - d0, 1);

        // VADD mem[0..3] + mem[8..11] -> dest 30 wrapping
        w0 = wn;
        send(6'd2, 5'd0, 5'd8, 5'd30, 3'd4, 0, E);
        settle();
        chk("vadd_nwrites", wn - w0, 4);
        chk("vadd_w0", {wlog_a[w0], wlog_d[w0]}, {5'd30, 16'hFFEB});
        chk("vadd_w1", {wlog_a[w0+1], wlog_d[w0+1]}, {5'd31, 16'hFFE9});
        chk("vadd_w2", {wlog_a[w0+2], wlog_d[w0+2]}, {5'd0, 16'd12});
        chk("vadd_w3", {wlog_a[w0+3], wlog_d[w0+3]}, {5'd1, 16'd14});

        // VSMUL length 0 -> full 8-word buffer, scalar mem[2] = 5
        w0 = wn;
        send(6'd5, 5'd8, 5'd2, 5'd16, 3'd0, 0, E);
        settle();
        chk("vsmul_nwrites", wn - w0, 8);
        chk("vsmul_w0", {wlog_a[w0], wlog_d[w0]}, {5'd16, 16'hFF88});
        chk("vsmul_w2", {wlog_a[w0+2], wlog_d[w0+2]}, {5'd18, 16'd35});
        chk("vsmul_w7", {wlog_a[w0+7], wlog_d[w0+7]}, {5'd23, 16'hFF1F});

        // RELU of -24,-27,7 -> 0,0,7
        w0 = wn;
        send(6'd4, 5'd8, 5'd26, 5'd3, 3'd0, 0, E);
        settle();
        chk("relu_nwrites", wn - w0, 3);
        chk("relu_w0", {wlog_a[w0], wlog_d[w0]}, {5'd26, 16'd0});
        chk("relu_w2", {wlog_a[w0+2], wlog_d[w0+2]}, {5'd28, 16'd7});

        // Illegal opcodes: err+done, nothing issued or written
        foreach (bad_ops[i]) begin
            w0 = wn; e0 = en;
            send(bad_ops[i], 5'd1, 5'd2, 5'd3, 3'd1, 0, E);
            settle();
            chk("illegal_no_write", wn - w0, 0);
            chk("illegal_err", en - e0, 1);
        end

        // NOP retires alone
        d0 = dn; e0 = en; w0 = wn;
        send(6'd0, 5'd0, 5'd0, 5'd0, 3'd0, 0, E);
        settle();
        chk("nop_done", dn - d0, 1);
        chk("nop_no_err", en - e0, 0);
        chk("nop_no_write", wn - w0, 0);

        // VPU withholds the copy flag: error, no writes
        drop_flag = 1'b1;
        w0 = wn; e0 = en;
        send(6'd3, 5'd4, 5'd12, 5'd3, 3'd0, 0, E);
        settle();
        drop_flag = 1'b0;
        chk("noflag_no_write", wn - w0, 0);
        chk("noflag_err", en - e0, 1);

        // Back-to-back MOVEs with valid held; second reads the first's output
        w0 = wn;
        send(6'd3, 5'd4, 5'd20, 5'd2, 3'd0, 1, E);
        send(6'd3, 5'd20, 5'd24, 5'd2, 3'd0, 0, E2);
        settle();
        chk("b2b_accept_gap", E2 - E, 5);
        chk("b2b_nwrites", wn - w0, 4);
        chk("b2b_w2", {wlog_a[w0+2], wlog_d[w0+2]}, {5'd24, 16'd7});
        chk("b2b_w3", {wlog_a[w0+3], wlog_d[w0+3]}, {5'd25, 16'd8});

        // Reset during the second write of a 5-word MOVE aborts at once
        w0 = wn;
        send(6'd3, 5'd4, 5'd27, 5'd5, 3'd0, 0, E);
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b0;
        m_act = 0; m_o1 = '0; m_o2 = '0; m_o3 = '0; m_o4 = '0;
        #1;
        chk("abort_mem_we", mem_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_writes_logged", wn - w0, 2);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("post_rst_ready", instr_ready, 1);
        chk("post_rst_we", mem_we, 0);
`ifdef VPU_SEQ_PERF_CNT_EN
        chk("post_rst_perf_instr", perf_instr_cnt, 0);
        chk("post_rst_perf_word", perf_word_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
